incrementor: RTL and testbench
==============================

# incrementor

Combinational value-update unit with a registered copy, used by the memory address handler for program-counter advance and stack-pointer push/pop arithmetic. A 3-bit operation code selects hold, increment, decrement, force-to-empty, or load-from-limit applied to a supplied current value. The result is available combinationally on `next_value` and is also captured into an output register. Optional wrap flags report carry and borrow.

## Interface
- `DATA_WIDTH`, default 32: width of all value ports.
- `EMPTY_VALUE`, default all ones (`2**DATA_WIDTH-1`): value produced by the force-empty operation. It is the stack "empty" sentinel.
- `clock`  in  1: single clock. Rising edge active.
- `reset`  in  1: asynchronous, active-low reset.
- `enable`  in  1: register capture enable.
- `control`  in  3: operation code.
- `current_value`  in  DATA_WIDTH: operand.
- `limit`  in  DATA_WIDTH: load value for op 4 (stack first-slot address, or PC restart value).
- `next_value`  out  DATA_WIDTH: combinational result.
- `value_q`  out  DATA_WIDTH: registered result.
- `carry_q`, `borrow_q`  out  1 each: registered wrap flags. Present only with `INCREMENTOR_WRAP_FLAGS_EN`.

## Operation
- `next_value` is a pure function of `control`, `current_value`, and `limit`. It does not depend on the clock, reset, or enable.
- Operation codes:
  - 0: hold, `next_value = current_value`.
  - 1: increment, `current_value + 1` modulo 2^DATA_WIDTH.
  - 2: decrement, `current_value - 1` modulo 2^DATA_WIDTH.
  - 3: force empty, `EMPTY_VALUE`.
  - 4: load, `limit`.
  - 5–7: reserved. Behave exactly as hold.
- Wrap-around:
  - Increment of all ones gives 0. The carry condition is true.
  - Decrement of 0 gives all ones. The borrow condition is true.
  - No saturation in either direction.
  - The carry and borrow conditions are false for every other op and operand.
- `limit` is ignored for every op except 4.
- `current_value` is ignored for ops 3 and 4.

## Timing
- `next_value` has zero latency, combinational from the inputs.
- `value_q` takes `next_value` on the rising edge of `clock` when `enable` = 1. Otherwise it holds. One-cycle latency.
- When `reset` goes low, `value_q` goes to 0 immediately, asynchronously. The flags also go to 0.
- Reset has priority over `enable`.
- The first capture happens on the first rising edge after `reset` is deasserted.
- Reset asserted mid-operation discards the pending capture. `next_value` keeps tracking its inputs while reset is asserted.

## Configuration
- Macro `INCREMENTOR_WRAP_FLAGS_EN`.
- Defined:
  - `carry_q` and `borrow_q` exist.
  - Each is registered alongside `value_q` with the same enable and reset rules.
  - `carry_q` is set when a captured op-1 result wrapped. `borrow_q` is set when a captured op-2 result wrapped.
  - Both are cleared on any captured non-wrapping op.
- Undefined: the flag ports and their logic are absent. All other behaviour is identical.

## Structure
- Shared package `incrementor_pkg` holds:
  - the operation-code constants: `OP_HOLD` = 0, `OP_INC` = 1, `OP_DEC` = 2, `OP_EMPTY` = 3, `OP_LOAD` = 4;
  - the `EMPTY_VALUE` default.
- The address handler imports the same package.
- No sub-module. One combinational case block and one register process.

## Test plan
- Op 1 with `current_value` = 0x0000_0FFF → `next_value` = 0x0000_1000. With `enable` = 1, `value_q` = 0x0000_1000 after one edge.
- Op 2 with `current_value` = 0x0000_1800 → `next_value` = 0x0000_17FF. Op 2 with `current_value` = 0 → 0xFFFF_FFFF, and `borrow_q` = 1 after the edge (flags build).
- Op 3 with any operand → `next_value` = 0xFFFF_FFFF. Op 1 on 0xFFFF_FFFF → 0, and `carry_q` = 1.
- Op 4 with `limit` = 0x0000_1FFF and `current_value` = 0xFFFF_FFFF → `next_value` = 0x0000_1FFF. Ops 0 and 5–7 with `current_value` = 0x1234 → `next_value` = 0x1234.
- `enable` = 0 for 3 edges while op 1 is applied → `value_q` is unchanged. Raising `enable` captures on the next edge.
- Drive `reset` low between edges while `value_q` = 0x55 → `value_q` = 0 before the next edge. It stays 0 until `reset` is high and `enable` is high at an edge.

Source files
------------

// File: rtl/incrementor_pkg.sv
// incrementor_pkg
// Shared constants for the incrementor and the memory address handler that
// drives it: the 3-bit operation codes and the default "stack empty"
// sentinel. Codes 5..7 are reserved and decode as hold.
package incrementor_pkg;

  localparam logic [2:0] OP_HOLD  = 3'd0;
  localparam logic [2:0] OP_INC   = 3'd1;
  localparam logic [2:0] OP_DEC   = 3'd2;
  localparam logic [2:0] OP_EMPTY = 3'd3;
  localparam logic [2:0] OP_LOAD  = 3'd4;

  localparam int DATA_WIDTH_DEFAULT = 32;

  // All ones at the widest supported value width; instances slice it down
  // to their own DATA_WIDTH (DATA_WIDTH must not exceed 64).
  localparam logic [63:0] EMPTY_VALUE_DEFAULT = '1;

endpackage

// File: rtl/incrementor.sv
// incrementor
// Value-update unit for program-counter advance and stack-pointer push/pop.
// The selected operation is applied combinationally to current_value and the
// result is also captured into value_q when enable is high.
//
// Optional build macro: INCREMENTOR_WRAP_FLAGS_EN adds the registered wrap
// flags carry_q (captured increment wrapped) and borrow_q (captured decrement
// wrapped).
//
// Ports:
//   clock         in   rising-edge clock
//   reset         in   asynchronous active-low reset (clears value_q / flags)
//   enable        in   capture enable for the output register
//   control       in   [2:0] op code: 0 hold, 1 inc, 2 dec, 3 empty, 4 load
//   current_value in   [DATA_WIDTH-1:0] operand
//   limit         in   [DATA_WIDTH-1:0] load value, used only by op 4
//   next_value    out  [DATA_WIDTH-1:0] combinational result
//   value_q       out  [DATA_WIDTH-1:0] registered result
//   carry_q       out  registered increment wrap flag (macro builds only)
//   borrow_q      out  registered decrement wrap flag (macro builds only)
module incrementor
  import incrementor_pkg::*;
#(
  parameter int                    DATA_WIDTH  = DATA_WIDTH_DEFAULT,
  parameter logic [DATA_WIDTH-1:0] EMPTY_VALUE = EMPTY_VALUE_DEFAULT[DATA_WIDTH-1:0]
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [2:0]            control,
  input  logic [DATA_WIDTH-1:0] current_value,
  input  logic [DATA_WIDTH-1:0] limit,
  output logic [DATA_WIDTH-1:0] next_value,
`ifdef INCREMENTOR_WRAP_FLAGS_EN
  output logic                  carry_q,
  output logic                  borrow_q,
`endif
  output logic [DATA_WIDTH-1:0] value_q
);

  // Stage p0: combinational operation decode.
  // Increment and decrement wrap modulo 2^DATA_WIDTH; there is no saturation.
  always_comb begin
    next_value = current_value;
    case (control)
      OP_INC:   next_value = current_value + DATA_WIDTH'(1);
      OP_DEC:   next_value = current_value - DATA_WIDTH'(1);
      OP_EMPTY: next_value = EMPTY_VALUE;
      OP_LOAD:  next_value = limit;
      default:  next_value = current_value;
    endcase
  end

`ifdef INCREMENTOR_WRAP_FLAGS_EN
  logic carry_p0;
  logic borrow_p0;

  always_comb begin
    carry_p0  = (control == OP_INC) && (&current_value);
    borrow_p0 = (control == OP_DEC) && (current_value == '0);
  end
`endif

  // Stage p1: output register. Reset clears everything and wins over enable.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      value_q  <= '0;
`ifdef INCREMENTOR_WRAP_FLAGS_EN
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
`endif
    end else if (enable) begin
      value_q  <= next_value;
`ifdef INCREMENTOR_WRAP_FLAGS_EN
      carry_q  <= carry_p0;
      borrow_q <= borrow_p0;
`endif
    end
  end

endmodule

// File: tb/tb_incrementor.sv
// tb_incrementor
// Self-checking bench for incrementor (DATA_WIDTH = 32): a vector table,
// hand-written enable/reset sequences, and randomized traffic compared
// against an arithmetic reference model.
module tb_incrementor;

  localparam int  W    = 32;
  localparam longint MOD = 64'd1 << W;

  logic          clock;
  logic          reset;
  logic          enable;
  logic [2:0]    control;
  logic [W-1:0]  current_value;
  logic [W-1:0]  limit;
  logic [W-1:0]  next_value;
  logic [W-1:0]  value_q;
`ifdef INCREMENTOR_WRAP_FLAGS_EN
  logic          carry_q;
  logic          borrow_q;
`endif

  incrementor #(.DATA_WIDTH(W)) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .control       (control),
    .current_value (current_value),
    .limit         (limit),
    .next_value    (next_value),
`ifdef INCREMENTOR_WRAP_FLAGS_EN
    .carry_q       (carry_q),
    .borrow_q      (borrow_q),
`endif
    .value_q       (value_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Reference model: plain modular arithmetic on the op-code rules.
  function automatic logic [W-1:0] ref_next(input int op, input longint cur, input longint lim);
    longint r;
    case (op)
      1:       r = (cur + 1) % MOD;
      2:       r = (cur + MOD - 1) % MOD;
      3:       r = MOD - 1;
      4:       r = lim;
      default: r = cur;
    endcase
    return r[W-1:0];
  endfunction

  function automatic logic ref_carry(input int op, input longint cur);
    return (op == 1) && (cur == MOD - 1);
  endfunction

  function automatic logic ref_borrow(input int op, input longint cur);
    return (op == 2) && (cur == 0);
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic [2:0]   ctrl;
    logic [W-1:0] cur;
    logic [W-1:0] lim;
    logic [W-1:0] exp;
    logic         exp_c;
    logic         exp_b;
  } vec_t;

  vec_t vecs[12];

  logic [W-1:0] exp_q;
  logic         exp_c_q;
  logic         exp_b_q;

  initial begin
    vecs[0]  = '{3'd1, 32'h0000_0FFF, 32'h0,         32'h0000_1000, 1'b0, 1'b0};
    vecs[1]  = '{3'd2, 32'h0000_1800, 32'h0,         32'h0000_17FF, 1'b0, 1'b0};
    vecs[2]  = '{3'd2, 32'h0000_0000, 32'h0,         32'hFFFF_FFFF, 1'b0, 1'b1};
    vecs[3]  = '{3'd3, 32'h1234_5678, 32'h9,         32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[4]  = '{3'd1, 32'hFFFF_FFFF, 32'h0,         32'h0000_0000, 1'b1, 1'b0};
    vecs[5]  = '{3'd4, 32'hFFFF_FFFF, 32'h0000_1FFF, 32'h0000_1FFF, 1'b0, 1'b0};
    vecs[6]  = '{3'd0, 32'h0000_1234, 32'hAAAA,      32'h0000_1234, 1'b0, 1'b0};
    vecs[7]  = '{3'd5, 32'h0000_1234, 32'hAAAA,      32'h0000_1234, 1'b0, 1'b0};
    vecs[8]  = '{3'd6, 32'h0000_1234, 32'hAAAA,      32'h0000_1234, 1'b0, 1'b0};
    vecs[9]  = '{3'd7, 32'h0000_1234, 32'hAAAA,      32'h0000_1234, 1'b0, 1'b0};
    vecs[10] = '{3'd3, 32'h0000_0000, 32'h0,         32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[11] = '{3'd2, 32'hFFFF_FFFF, 32'h0,         32'hFFFF_FFFE, 1'b0, 1'b0};

    reset = 1'b0; enable = 1'b0; control = 3'd0;
    current_value = '0; limit = '0;

    // Reset state.
    #12;
    check("reset_value_q", value_q, '0);
`ifdef INCREMENTOR_WRAP_FLAGS_EN
    check("reset_carry_q", W'(carry_q), '0);
    check("reset_borrow_q", W'(borrow_q), '0);
`endif
    // next_value tracks inputs even while reset is held.
    control = 3'd1; current_value = 32'h0000_00FF; #1;
    check("next_in_reset", next_value, 32'h0000_0100);
    #1 reset = 1'b1;
    step();

    // Vector table: combinational result, then registered capture.
    enable = 1'b1;
    foreach (vecs[i]) begin
      control = vecs[i].ctrl; current_value = vecs[i].cur; limit = vecs[i].lim;
      #1;
      check($sformatf("vec%0d_next", i), next_value, vecs[i].exp);
      step();
      check($sformatf("vec%0d_q", i), value_q, vecs[i].exp);
`ifdef INCREMENTOR_WRAP_FLAGS_EN
      check($sformatf("vec%0d_carry", i), W'(carry_q), W'(vecs[i].exp_c));
      check($sformatf("vec%0d_borrow", i), W'(borrow_q), W'(vecs[i].exp_b));
`endif
    end

    // Enable low holds the register across three edges, then captures.
    control = 3'd4; limit = 32'h0000_0100; enable = 1'b1;
    step();
    check("hold_load", value_q, 32'h0000_0100);
    control = 3'd1; current_value = 32'h0000_0100; enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("hold_edge%0d", k), value_q, 32'h0000_0100);
    end
    enable = 1'b1;
    step();
    check("enable_capture", value_q, 32'h0000_0101);

    // Asynchronous reset between edges while value_q = 0x55.
    control = 3'd4; limit = 32'h55;
    step();
    check("pre_reset_55", value_q, 32'h55);
    #2 reset = 1'b0;
    #1 check("async_reset_clear", value_q, '0);
    step();  // edge with reset low and enable high: nothing captured
    check("reset_priority", value_q, '0);
    #1 reset = 1'b1; enable = 1'b0;
    step();
    check("post_reset_no_en", value_q, '0);
    enable = 1'b1;
    step();
    check("post_reset_capture", value_q, 32'h55);

    // Randomized traffic against the model.
    exp_q = value_q; exp_c_q = 1'b0; exp_b_q = 1'b0;
`ifdef INCREMENTOR_WRAP_FLAGS_EN
    exp_c_q = carry_q; exp_b_q = borrow_q;
`endif
    for (int n = 0; n < 300; n++) begin
      int op;
      logic [W-1:0] cur, lim;
      op = int'($urandom_range(7));
      case ($urandom_range(3))
        0:       cur = '0;
        1:       cur = '1;
        default: cur = $urandom;
      endcase
      lim = $urandom;
      control = op[2:0]; current_value = cur; limit = lim;
      enable = ($urandom_range(3) != 0);
      #1;
      check("rand_next", next_value, ref_next(op, longint'(cur), longint'(lim)));
      if (enable) begin
        exp_q   = ref_next(op, longint'(cur), longint'(lim));
        exp_c_q = ref_carry(op, longint'(cur));
        exp_b_q = ref_borrow(op, longint'(cur));
      end
      step();
      check("rand_q", value_q, exp_q);
`ifdef INCREMENTOR_WRAP_FLAGS_EN
      check("rand_carry", W'(carry_q), W'(exp_c_q));
      check("rand_borrow", W'(borrow_q), W'(exp_b_q));
`endif
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
